// File: rtl/mac_pkg.sv
// Shared encodings for the systolic MAC array sequencer.
package mac_pkg;

  // Sequencer phases
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_FLUSH  = 3'd5,
    ST_DONE   = 3'd6
  } mac_state_e;

  // Array instruction lines: bit1 = execute, bit0 = kernel load
  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  // Dataflow modes
  localparam logic MODE_WS = 1'b0;
  localparam logic MODE_OS = 1'b1;

endpackage

// File: rtl/mac_array_ctrl.sv
// Job sequencer for the systolic MAC array: kernel load, settle, execute,
// drain and optional output-stationary flush, then a one-cycle done pulse.
module mac_array_ctrl
  import mac_pkg::*;
#(
  parameter int unsigned row    = 8,
  parameter int unsigned col    = 8,
  parameter int unsigned len_bw = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode_in,
  input  logic [len_bw-1:0] exec_len,
  input  logic              l0_empty,
  input  logic [col-1:0]    valid,
  input  logic              ofifo_full,
  output logic [1:0]        inst_w,
  output logic              mode,
  output logic              flush,
  output logic              l0_rd,
  output logic              ofifo_wr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Phase counter is sized for the longest phase so it never wraps
  localparam int unsigned LEN_MAX = (2 ** len_bw) - 1;
  localparam int unsigned CNT_MAX = ((row + col) > LEN_MAX) ? (row + col) : LEN_MAX;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t LOAD_LAST   = cnt_t'(row - 1);
  localparam cnt_t SETTLE_LAST = cnt_t'(col - 1);
  localparam cnt_t DRAIN_LAST  = cnt_t'(row + col - 1);
  localparam cnt_t FLUSH_LAST  = cnt_t'(col - 1);

  mac_state_e        state_q, state_d;
  cnt_t              cnt_q, cnt_d;
  logic              mode_q, mode_d;
  logic [len_bw-1:0] len_q, len_d;
  logic              err_q, err_d;

  logic any_valid;
  assign any_valid = |valid;

  // Next-state, phase counter, latched job fields and sticky overflow
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    len_d   = len_q;
    err_d   = err_q | (any_valid & ofifo_full);
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d = mode_in;
          len_d  = exec_len;
          cnt_d  = '0;
          if (mode_in == MODE_WS)     state_d = ST_LOAD;
          else if (exec_len == '0)    state_d = ST_DRAIN;
          else                        state_d = ST_EXEC;
        end
      end
      ST_LOAD: begin
        if (!l0_empty) begin
          if (cnt_q == LOAD_LAST) begin
            state_d = ST_SETTLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + cnt_t'(1);
          end
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = (len_q == '0) ? ST_DRAIN : ST_EXEC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      ST_EXEC: begin
        // Compare against count+1 so a zero-based counter needs no length-1 term
        if (!l0_empty) begin
          if ((cnt_q + cnt_t'(1)) == cnt_t'(len_q)) begin
            state_d = ST_DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + cnt_t'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = (mode_q == MODE_OS) ? ST_FLUSH : ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      ST_FLUSH: begin
        if (cnt_q == FLUSH_LAST) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and job registers; reset abandons any job in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

  // Output decode; a stalled LOAD/EXEC cycle issues no instruction or read
  always_comb begin
    inst_w = INST_IDLE;
    l0_rd  = 1'b0;
    if (!l0_empty) begin
      if (state_q == ST_LOAD) begin
        inst_w = INST_LOAD;
        l0_rd  = 1'b1;
      end else if (state_q == ST_EXEC) begin
        inst_w = INST_EXEC;
        l0_rd  = 1'b1;
      end
    end
  end

  assign flush    = (state_q == ST_FLUSH);
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign mode     = mode_q;
  assign err      = err_q;
  assign ofifo_wr = any_valid & ~ofifo_full;

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Scoreboard bench for mac_array_ctrl: per-cycle expected outputs are queued
// from phase lengths when a job is launched and compared as cycles elapse.
module tb_mac_array_ctrl;
  import mac_pkg::*;

  localparam int unsigned ROW = 8;
  localparam int unsigned COL = 8;
  localparam int unsigned LBW = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           mode_in;
  logic [LBW-1:0] exec_len;
  logic           l0_empty;
  logic [COL-1:0] valid;
  logic           ofifo_full;
  logic [1:0]     inst_w;
  logic           mode, flush, l0_rd, ofifo_wr, busy, done, err;

  mac_array_ctrl #(.row(ROW), .col(COL), .len_bw(LBW)) dut (
    .clk(clk), .reset(reset), .start(start), .mode_in(mode_in),
    .exec_len(exec_len), .l0_empty(l0_empty), .valid(valid),
    .ofifo_full(ofifo_full), .inst_w(inst_w), .mode(mode), .flush(flush),
    .l0_rd(l0_rd), .ofifo_wr(ofifo_wr), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] inst_w;
    logic       l0_rd;
    logic       flush;
    logic       busy;
    logic       done;
    logic       mode;
  } exp_t;

  exp_t exp_q[$];
  bit   stall_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] iw, input logic rd, input logic fl,
                      input logic bz, input logic dn, input logic m, input bit st);
    exp_t e;
    e.inst_w = iw; e.l0_rd = rd; e.flush = fl; e.busy = bz; e.done = dn; e.mode = m;
    exp_q.push_back(e);
    stall_q.push_back(st);
  endtask

  // Expected trace from cycle 1 (after the start edge) to the first idle cycle
  task automatic build_job(input logic m, input int len, input int s0, input int sn);
    int c = 1;
    int act;
    bit st;
    if (m == MODE_WS) begin
      act = 0;
      while (act < ROW) begin
        st = (c >= s0) && (c < s0 + sn);
        if (st) push(2'b00, 0, 0, 1, 0, m, 1);
        else begin push(2'b01, 1, 0, 1, 0, m, 0); act++; end
        c++;
      end
      for (int i = 0; i < COL; i++) begin push(2'b00, 0, 0, 1, 0, m, 0); c++; end
    end
    act = 0;
    while (act < len) begin
      st = (c >= s0) && (c < s0 + sn);
      if (st) push(2'b00, 0, 0, 1, 0, m, 1);
      else begin push(2'b10, 1, 0, 1, 0, m, 0); act++; end
      c++;
    end
    for (int i = 0; i < ROW + COL; i++) begin push(2'b00, 0, 0, 1, 0, m, 0); c++; end
    if (m == MODE_OS)
      for (int i = 0; i < COL; i++) begin push(2'b00, 0, 1, 1, 0, m, 0); c++; end
    push(2'b00, 0, 0, 1, 1, m, 0);
    push(2'b00, 0, 0, 0, 0, m, 0);
  endtask

  task automatic run_job(input logic m, input int len, input int s0, input int sn,
                         input bit poke_start, input bit rand_valid, output int done_cyc);
    exp_t e;
    exp_t g;
    bit   st;
    int   c = 1;
    done_cyc = -1;
    build_job(m, len, s0, sn);
    @(posedge clk); #1;
    start = 1'b1; mode_in = m; exec_len = LBW'(len); l0_empty = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      st = stall_q.pop_front();
      l0_empty = st;
      if (poke_start && (c % 5 == 2) && exp_q.size() > 1) begin
        start = 1'b1; mode_in = ~m; exec_len = LBW'($urandom_range(0, 255));
      end else start = 1'b0;
      if (rand_valid) begin valid = COL'($urandom); ofifo_full = 1'b0; end
      else valid = '0;
      @(negedge clk);
      g.inst_w = inst_w; g.l0_rd = l0_rd; g.flush = flush; g.busy = busy;
      g.done = done; g.mode = mode;
      chk($sformatf("trace_c%0d", c), 32'(g), 32'(e));
      if (rand_valid) chk("ofifo_wr", 32'(ofifo_wr), 32'(|valid));
      if (done && done_cyc < 0) done_cyc = c;
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0; valid = '0; l0_empty = 1'b0;
  endtask

  int dc;

  initial begin
    reset = 1'b1; start = 1'b0; mode_in = 1'b0; exec_len = '0;
    l0_empty = 1'b0; valid = '0; ofifo_full = 1'b0;
    #3;
    chk("reset_outs", 32'({inst_w, mode, flush, l0_rd, ofifo_wr, busy, done, err}), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    run_job(MODE_WS, 16, 0, 0, 0, 1, dc); chk("ws16_done_cyc", 32'(dc), 32'd49);
    run_job(MODE_OS, 4, 0, 0, 1, 0, dc);  chk("os4_done_cyc", 32'(dc), 32'd29);
    run_job(MODE_WS, 16, 4, 3, 0, 0, dc); chk("ws_stall_done_cyc", 32'(dc), 32'd52);
    run_job(MODE_OS, 0, 0, 0, 0, 0, dc);  chk("os0_done_cyc", 32'(dc), 32'd25);
    run_job(MODE_WS, 0, 0, 0, 0, 0, dc);  chk("ws0_done_cyc", 32'(dc), 32'd33);
    run_job(MODE_OS, 3, 2, 2, 1, 0, dc);  chk("os_stall_done_cyc", 32'(dc), 32'd30);

    // Overflow: write suppressed, sticky flag survives valid dropping
    @(posedge clk); #1;
    valid = 8'h01; ofifo_full = 1'b1;
    @(negedge clk);
    chk("ovf_wr", 32'(ofifo_wr), 32'h0);
    chk("ovf_err_pre", 32'(err), 32'h0);
    @(posedge clk); #1;
    valid = '0;
    @(negedge clk);
    chk("ovf_err_set", 32'(err), 32'h1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ovf_err_held", 32'(err), 32'h1);
    ofifo_full = 1'b0;

    // Reset mid-EXEC
    @(posedge clk); #1;
    start = 1'b1; mode_in = MODE_OS; exec_len = 8'd10;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    chk("pre_rst_exec", 32'({inst_w, busy, mode}), 32'({INST_EXEC, 1'b1, 1'b1}));
    reset = 1'b1;
    #1;
    chk("async_rst_outs", 32'({inst_w, mode, flush, l0_rd, ofifo_wr, busy, done, err}), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_idle", 32'({busy, done, err}), 32'h0);
    end
    run_job(MODE_OS, 4, 0, 0, 0, 0, dc); chk("post_rst_done_cyc", 32'(dc), 32'd29);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
